// File: rtl/l1_sram_req_sequencer.sv
// Request sequencer in front of the L1 SRAM wrapper: one outstanding single-word
// access, with held pin timing, a read timeout and a quiet gap between accesses.
module l1_sram_req_sequencer #(
    parameter int ADDR_WIDTH        = 9,
    parameter int DATA_WIDTH        = 32,
    parameter int NUM_WMASKS        = 4,
    parameter int STARTUP_CYCLES    = 16,
    parameter int WRITE_HOLD_CYCLES = 8,
    parameter int READ_TIMEOUT      = 64,
    parameter int GAP_CYCLES        = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [NUM_WMASKS-1:0] req_wmask,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [DATA_WIDTH-1:0] sram_data_in,
    output logic                  sram_we,
    output logic                  sram_csb,
    output logic [NUM_WMASKS-1:0] sram_wmask,
    input  logic [DATA_WIDTH-1:0] sram_data_out,
    input  logic                  sram_data_ready,
    output logic                  busy
);

    localparam int MAX_A   = (STARTUP_CYCLES > WRITE_HOLD_CYCLES) ? STARTUP_CYCLES : WRITE_HOLD_CYCLES;
    localparam int MAX_B   = (READ_TIMEOUT > GAP_CYCLES) ? READ_TIMEOUT : GAP_CYCLES;
    localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_RD_WAIT,
        S_WR_HOLD,
        S_GAP
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   req_ready_d, busy_d;
    logic                   resp_valid_d, resp_err_d;
    logic [DATA_WIDTH-1:0]  resp_rdata_d;
    logic [ADDR_WIDTH-1:0]  sram_addr_d;
    logic [DATA_WIDTH-1:0]  sram_data_in_d;
    logic                   sram_we_d, sram_csb_d;
    logic [NUM_WMASKS-1:0]  sram_wmask_d;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
        state_d        = state_q;
        cnt_d          = cnt_q + CNT_W'(1);
        req_ready_d    = req_ready;
        busy_d         = busy;
        resp_valid_d   = 1'b0;
        resp_err_d     = 1'b0;
        resp_rdata_d   = '0;
        sram_addr_d    = sram_addr;
        sram_data_in_d = sram_data_in;
        sram_we_d      = sram_we;
        sram_csb_d     = sram_csb;
        sram_wmask_d   = sram_wmask;

        unique case (state_q)
            S_INIT: begin
                if (cnt_q == CNT_W'(STARTUP_CYCLES - 1)) begin
                    state_d     = S_IDLE;
                    cnt_d       = '0;
                    req_ready_d = 1'b1;
                    busy_d      = 1'b0;
                end
            end

            S_IDLE: begin
                cnt_d = '0;
                if (req_valid && req_ready) begin
                    req_ready_d = 1'b0;
                    busy_d      = 1'b1;
                    sram_addr_d = req_addr;
                    sram_csb_d  = 1'b0;
                    if (req_write) begin
                        sram_we_d      = 1'b0;
                        sram_wmask_d   = req_wmask;
                        sram_data_in_d = req_wdata;
                        state_d        = S_WR_HOLD;
                    end else begin
                        sram_we_d    = 1'b1;
                        sram_wmask_d = '0;
                        state_d      = S_RD_WAIT;
                    end
                end
            end

            S_WR_HOLD: begin
                if (cnt_q == CNT_W'(WRITE_HOLD_CYCLES - 1)) begin
                    resp_valid_d = 1'b1;
                    sram_csb_d   = 1'b1;
                    sram_we_d    = 1'b1;
                    sram_wmask_d = '0;
                    state_d      = S_GAP;
                    cnt_d        = '0;
                end
            end

            S_RD_WAIT: begin
                // Data arriving on the last allowed cycle still beats the timeout.
                if (sram_data_ready || cnt_q == CNT_W'(READ_TIMEOUT - 1)) begin
                    resp_valid_d = 1'b1;
                    resp_err_d   = ~sram_data_ready;
                    resp_rdata_d = sram_data_ready ? sram_data_out : '0;
                    sram_csb_d   = 1'b1;
                    sram_we_d    = 1'b1;
                    sram_wmask_d = '0;
                    state_d      = S_GAP;
                    cnt_d        = '0;
                end
            end

            S_GAP: begin
                // The response cycle opens GAP; GAP_CYCLES quiet cycles follow it.
                if (cnt_q == CNT_W'(GAP_CYCLES)) begin
                    state_d     = S_IDLE;
                    cnt_d       = '0;
                    req_ready_d = 1'b1;
                    busy_d      = 1'b0;
                end
            end

            default: begin
                state_d = S_INIT;
                cnt_d   = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_INIT;
            cnt_q        <= '0;
            req_ready    <= 1'b0;
            busy         <= 1'b1;
            resp_valid   <= 1'b0;
            resp_err     <= 1'b0;
            resp_rdata   <= '0;
            sram_addr    <= '0;
            sram_data_in <= '0;
            sram_we      <= 1'b1;
            sram_csb     <= 1'b1;
            sram_wmask   <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            req_ready    <= req_ready_d;
            busy         <= busy_d;
            resp_valid   <= resp_valid_d;
            resp_err     <= resp_err_d;
            resp_rdata   <= resp_rdata_d;
            sram_addr    <= sram_addr_d;
            sram_data_in <= sram_data_in_d;
            sram_we      <= sram_we_d;
            sram_csb     <= sram_csb_d;
            sram_wmask   <= sram_wmask_d;
        end
    end

endmodule

// File: tb/tb_l1_sram_req_sequencer.sv
// Directed bench for l1_sram_req_sequencer: a vector table of single requests
// against a small wrapper model, plus INIT, back-to-back and mid-access reset sequences.
module tb_l1_sram_req_sequencer;

    localparam int GAP = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [8:0]  req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_wmask = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [8:0]  sram_addr;
    logic [31:0] sram_data_in;
    logic        sram_we;
    logic        sram_csb;
    logic [3:0]  sram_wmask;
    logic [31:0] sram_data_out = '0;
    logic        sram_data_ready = 1'b0;
    logic        busy;

    l1_sram_req_sequencer dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .sram_addr(sram_addr), .sram_data_in(sram_data_in), .sram_we(sram_we),
        .sram_csb(sram_csb), .sram_wmask(sram_wmask),
        .sram_data_out(sram_data_out), .sram_data_ready(sram_data_ready),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          wr;
        logic [8:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        int          rd_lat;     // data_ready at T+rd_lat; 0 = never
        int          late;       // extra data_ready at T+late; 0 = none
        logic [31:0] exp_rdata;
        bit          exp_err;
        int          exp_off;    // response cycle relative to handshake T
    } vec_t;

    vec_t        vecs [10];
    logic [31:0] wmem [512];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          rd_lat = 0;
    int          rd_age = 0;
    int          inject_at = -1;
    logic [31:0] datas[$];
    logic [8:0]  addrs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Wrapper model: commits writes from the pins, pulses data_ready rd_lat cycles into a read.
    task automatic step();
        if (!sram_csb && !sram_we)
            for (int b = 0; b < 4; b++)
                if (sram_wmask[b]) wmem[sram_addr][8*b +: 8] = sram_data_in[8*b +: 8];
        @(posedge clk);
        #1;
        cyc++;
        if (!sram_csb && sram_we) rd_age++;
        else rd_age = 0;
        sram_data_ready = (rd_lat != 0 && rd_age == rd_lat) || (cyc == inject_at);
        sram_data_out   = sram_data_ready ? wmem[sram_addr] : $urandom();
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " req_ready"},  req_ready,    1'b0);
        check({tag, " resp_valid"}, resp_valid,   1'b0);
        check({tag, " resp_rdata"}, resp_rdata,   32'h0);
        check({tag, " resp_err"},   resp_err,     1'b0);
        check({tag, " csb"},        sram_csb,     1'b1);
        check({tag, " we"},         sram_we,      1'b1);
        check({tag, " wmask"},      sram_wmask,   4'h0);
        check({tag, " addr"},       sram_addr,    9'h0);
        check({tag, " data_in"},    sram_data_in, 32'h0);
        check({tag, " busy"},       busy,         1'b1);
    endtask

    task automatic init_check(input string tag);
        int first_ready = -1;
        int bad_init = 0;
        cyc = 0;
        for (int c = 0; c < 40; c++) begin
            if (req_ready) begin
                first_ready = c;
                break;
            end
            if (!sram_csb || !sram_we || !busy) bad_init++;
            step();
        end
        check({tag, " first ready cycle"}, first_ready, 16);
        check({tag, " pins quiet"}, bad_init, 0);
    endtask

    task automatic do_txn(input vec_t v, input string tag);
        int waited = 0;
        int t0, nresp, resp_off, ready_off, low_cnt, quiet;
        bit stable;
        logic [31:0] got_rdata;
        logic got_err;
        while (!req_ready && waited < 200) begin
            step();
            waited++;
        end
        check({tag, " ready"}, req_ready, 1'b1);
        req_valid = 1'b1;
        req_write = v.wr;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        req_wmask = v.wmask;
        rd_lat    = v.rd_lat;
        t0        = cyc;
        inject_at = (v.late != 0) ? t0 + v.late : -1;
        step();
        req_valid = 1'b0;
        req_write = ~v.wr;
        req_addr  = ~v.addr;
        req_wdata = $urandom();
        req_wmask = ~v.wmask;
        check({tag, " T+1 csb"},       sram_csb,   1'b0);
        check({tag, " T+1 we"},        sram_we,    !v.wr);
        check({tag, " T+1 addr"},      sram_addr,  v.addr);
        check({tag, " T+1 wmask"},     sram_wmask, v.wr ? v.wmask : 4'h0);
        check({tag, " T+1 req_ready"}, req_ready,  1'b0);
        check({tag, " T+1 busy"},      busy,       1'b1);
        if (v.wr) check({tag, " T+1 data_in"}, sram_data_in, v.wdata);
        nresp = 0; resp_off = 0; ready_off = 0; low_cnt = 0; quiet = 0; stable = 1'b1;
        got_rdata = '0; got_err = 1'b0;
        for (int k = 1; k <= 150; k++) begin
            if (resp_valid) begin
                nresp++;
                if (nresp == 1) begin
                    resp_off  = k;
                    got_rdata = resp_rdata;
                    got_err   = resp_err;
                end
            end
            if (!sram_csb) begin
                low_cnt++;
                if (sram_addr != v.addr || sram_we != !v.wr ||
                    sram_wmask != (v.wr ? v.wmask : 4'h0) ||
                    (v.wr && sram_data_in != v.wdata)) stable = 1'b0;
            end
            if (sram_csb && busy && !resp_valid) quiet++;
            if (req_ready) begin
                ready_off = k;
                break;
            end
            step();
        end
        inject_at = -1;
        check({tag, " resp cycle"},   resp_off,  v.exp_off);
        check({tag, " resp_rdata"},   got_rdata, v.exp_rdata);
        check({tag, " resp_err"},     got_err,   v.exp_err);
        check({tag, " resp count"},   nresp,     1);
        check({tag, " active cycles"}, low_cnt,  v.exp_off - 1);
        check({tag, " pins stable"},  stable,    1'b1);
        check({tag, " gap cycles"},   quiet,     GAP);
        check({tag, " ready cycle"},  ready_off, v.exp_off + 1 + GAP);
    endtask

    initial begin
        int quiet;
        int waited;
        bit hs2;
        bit prev_csb;
        int bad_rst;

        for (int i = 0; i < 512; i++) wmem[i] = '0;
        //            wr    addr    wdata         wmask lat late exp_rdata     err off
        vecs[0] = '{1'b1, 9'h005, 32'hDEADBEEF, 4'hF, 0,  0,  32'h00000000, 1'b0, 9};
        vecs[1] = '{1'b0, 9'h005, 32'h0,        4'h0, 10, 0,  32'hDEADBEEF, 1'b0, 11};
        vecs[2] = '{1'b0, 9'h007, 32'h0,        4'h0, 0,  67, 32'h00000000, 1'b1, 65};
        vecs[3] = '{1'b1, 9'h1FF, 32'hCAFEF00D, 4'h5, 0,  0,  32'h00000000, 1'b0, 9};
        vecs[4] = '{1'b0, 9'h1FF, 32'h0,        4'h0, 1,  0,  32'h00FE000D, 1'b0, 2};
        vecs[5] = '{1'b0, 9'h005, 32'h0,        4'h0, 64, 0,  32'hDEADBEEF, 1'b0, 65};
        vecs[6] = '{1'b1, 9'h001, 32'h11111111, 4'hF, 0,  0,  32'h00000000, 1'b0, 9};
        vecs[7] = '{1'b1, 9'h002, 32'h22222222, 4'hF, 0,  0,  32'h00000000, 1'b0, 9};
        vecs[8] = '{1'b1, 9'h005, 32'h00000000, 4'h2, 0,  0,  32'h00000000, 1'b0, 9};
        vecs[9] = '{1'b0, 9'h005, 32'h0,        4'h0, 3,  0,  32'hDEAD00EF, 1'b0, 4};

        // Reset, with a write request already pending that INIT must ignore.
        #30;
        rst = 1'b0;
        #1;
        check_reset_vals("reset");
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 9'h005;
        req_wdata = 32'hDEADBEEF;
        req_wmask = 4'hF;
        init_check("init");

        for (int i = 0; i < 10; i++) do_txn(vecs[i], $sformatf("v%0d", i));

        // Back-to-back reads with req_valid held through the first access.
        rd_lat = 3;
        waited = 0;
        while (!req_ready && waited < 200) begin
            step();
            waited++;
        end
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 9'h001;
        step();
        req_addr = 9'h002;
        quiet = 0;
        hs2 = 1'b0;
        prev_csb = 1'b1;
        for (int k = 0; k < 100; k++) begin
            if (!sram_csb && prev_csb) addrs.push_back(sram_addr);
            prev_csb = sram_csb;
            if (resp_valid) datas.push_back(resp_rdata);
            if (datas.size() == 1 && sram_csb && busy && !resp_valid) quiet++;
            if (req_ready && req_valid) hs2 = 1'b1;
            if (datas.size() == 2 && req_ready) break;
            step();
            if (hs2) req_valid = 1'b0;
        end
        req_valid = 1'b0;
        check("b2b resp count", datas.size(), 2);
        check("b2b first data", datas[0], 32'h11111111);
        check("b2b second data", datas[1], 32'h22222222);
        check("b2b access count", addrs.size(), 2);
        check("b2b first addr", addrs[0], 9'h001);
        check("b2b second addr", addrs[1], 9'h002);
        check("b2b gap cycles", quiet, GAP);

        // Reset in the third RD_WAIT cycle of a read that never completes.
        rd_lat = 0;
        waited = 0;
        while (!req_ready && waited < 200) begin
            step();
            waited++;
        end
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 9'h005;
        step();
        req_valid = 1'b0;
        step();
        step();
        #2 rst = 1'b1;
        #1;
        check_reset_vals("midrst");
        bad_rst = 0;
        for (int k = 0; k < 3; k++) begin
            step();
            if (resp_valid || !sram_csb || req_ready) bad_rst++;
        end
        check("midrst held quiet", bad_rst, 0);
        #4 rst = 1'b0;
        req_valid = 1'b1;
        req_write = 1'b0;
        init_check("reinit");
        do_txn(vecs[9], "post-reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
